// File: rtl/knn_drv_pkg.sv
// Shared types and defaults for the KNN native-bus driver: FSM states,
// default KNN register word offsets and native write/read selectors.
package knn_drv_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWRst1,
    StWRst0,
    StWTestp,
    StWStart1,
    StGetPt,
    StWDatap,
    StWLabel,
    StWEn1,
    StWEn0,
    StWStart0,
    StRNb,
    StDone
  } drv_state_e;

  localparam int unsigned DEF_A_RESET  = 0;
  localparam int unsigned DEF_A_START  = 1;
  localparam int unsigned DEF_A_ENABLE = 2;
  localparam int unsigned DEF_A_TESTP  = 3;
  localparam int unsigned DEF_A_DATAP  = 4;
  localparam int unsigned DEF_A_LABEL  = 5;
  localparam int unsigned DEF_A_NB     = 6;

  // Write-enable values; the port expands them to all-ones / all-zero strobes.
  localparam logic NAT_WR = 1'b1;
  localparam logic NAT_RD = 1'b0;

  // States that own exactly one native transaction.
  function automatic logic is_bus_state(drv_state_e s);
    return !(s inside {StIdle, StGetPt, StDone});
  endfunction

endpackage

// File: rtl/nat_master_port.sv
// Single-transaction native initiator: captures a request, holds it until ready,
// then leaves valid low for at least one cycle before the next request.
module nat_master_port
  import knn_drv_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wd_i,
  output logic                  ack_o,
  output logic [DATA_W-1:0]     rd_o,
  output logic                  valid_o,
  output logic [ADDR_W-1:0]     address_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic                  ready_i
);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  // A request is only taken while idle, so the cycle after ready always shows valid low.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    if (valid_q) begin
      if (ready_i) valid_d = 1'b0;
    end else if (req_i) begin
      valid_d = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wd_d    = wd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      we_q    <= NAT_RD;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign ack_o     = valid_q & ready_i;
  assign rd_o      = rdata_i;
  assign valid_o   = valid_q;
  assign address_o = addr_q;
  assign wdata_o   = wd_q;
  assign wstrb_o   = {(DATA_W/8){we_q}};

endmodule

// File: rtl/knn_nat_driver.sv
// Hardware programmer for the KNN peripheral: soft-resets the core, loads the test
// point, streams data points with labels and reads back the neighbour list.
module knn_nat_driver
  import knn_drv_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned K        = 4,
  parameter int unsigned N_W      = 16,
  parameter int unsigned A_RESET  = DEF_A_RESET,
  parameter int unsigned A_START  = DEF_A_START,
  parameter int unsigned A_ENABLE = DEF_A_ENABLE,
  parameter int unsigned A_TESTP  = DEF_A_TESTP,
  parameter int unsigned A_DATAP  = DEF_A_DATAP,
  parameter int unsigned A_LABEL  = DEF_A_LABEL,
  parameter int unsigned A_NB     = DEF_A_NB,
  localparam int unsigned IdxW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [N_W-1:0]      n_points_i,
  input  logic [DATA_W-1:0]   testp_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic                pt_valid_i,
  output logic                pt_ready_o,
  input  logic [DATA_W-1:0]   pt_data_i,
  input  logic [DATA_W-1:0]   pt_label_i,
  output logic                res_valid_o,
  output logic [IdxW-1:0]     res_idx_o,
  output logic [DATA_W-1:0]   res_data_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  drv_state_e        state_q, state_d;
  logic [N_W-1:0]    n_q, n_d, cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] testp_q, testp_d, pt_q, pt_d, lab_q, lab_d;
  logic [IdxW-1:0]   nb_q, nb_d;
  logic              pt_ready_q, pt_ready_d;
  logic              pt_hs;

  logic              req, we, ack;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wd, rd;

  assign cnt_inc = cnt_q + N_W'(1);
  assign pt_hs   = pt_ready_q & pt_valid_i;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    testp_d    = testp_q;
    pt_d       = pt_q;
    lab_d      = lab_q;
    nb_d       = nb_q;
    pt_ready_d = 1'b0;
    req        = is_bus_state(state_q);
    we         = NAT_WR;
    addr       = '0;
    wd         = '0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          n_d     = n_points_i;
          testp_d = testp_i;
          cnt_d   = '0;
          state_d = StWRst1;
        end
      end
      StWRst1: begin
        addr = ADDR_W'(A_RESET);
        wd   = DATA_W'(1);
        if (ack) state_d = StWRst0;
      end
      StWRst0: begin
        addr = ADDR_W'(A_RESET);
        if (ack) state_d = StWTestp;
      end
      StWTestp: begin
        addr = ADDR_W'(A_TESTP);
        wd   = testp_q;
        if (ack) state_d = StWStart1;
      end
      StWStart1: begin
        addr = ADDR_W'(A_START);
        wd   = DATA_W'(1);
        if (ack) state_d = (n_q == '0) ? StWStart0 : StGetPt;
      end
      StGetPt: begin
        // Ready is a registered one-cycle pulse, re-armed only after it has dropped.
        if (pt_hs) begin
          pt_d    = pt_data_i;
          lab_d   = pt_label_i;
          state_d = StWDatap;
        end else begin
          pt_ready_d = pt_valid_i & ~pt_ready_q;
        end
      end
      StWDatap: begin
        addr = ADDR_W'(A_DATAP);
        wd   = pt_q;
        if (ack) state_d = StWLabel;
      end
      StWLabel: begin
        addr = ADDR_W'(A_LABEL);
        wd   = lab_q;
        if (ack) state_d = StWEn1;
      end
      StWEn1: begin
        addr = ADDR_W'(A_ENABLE);
        wd   = DATA_W'(1);
        if (ack) state_d = StWEn0;
      end
      StWEn0: begin
        addr = ADDR_W'(A_ENABLE);
        if (ack) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == n_q) ? StWStart0 : StGetPt;
        end
      end
      StWStart0: begin
        addr = ADDR_W'(A_START);
        if (ack) begin
          nb_d    = '0;
          state_d = StRNb;
        end
      end
      StRNb: begin
        we   = NAT_RD;
        addr = ADDR_W'(A_NB + 32'(nb_q));
        if (ack) begin
          nb_d = nb_q + IdxW'(1);
          if (nb_q == IdxW'(K - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      n_q        <= '0;
      cnt_q      <= '0;
      testp_q    <= '0;
      pt_q       <= '0;
      lab_q      <= '0;
      nb_q       <= '0;
      pt_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      testp_q    <= testp_d;
      pt_q       <= pt_d;
      lab_q      <= lab_d;
      nb_q       <= nb_d;
      pt_ready_q <= pt_ready_d;
    end
  end

  nat_master_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wd_i     (wd),
    .ack_o    (ack),
    .rd_o     (rd),
    .valid_o  (valid_o),
    .address_o(address_o),
    .wdata_o  (wdata_o),
    .wstrb_o  (wstrb_o),
    .rdata_i  (rdata_i),
    .ready_i  (ready_i)
  );

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign pt_ready_o  = pt_ready_q;
  assign res_valid_o = ack & (state_q == StRNb);
  assign res_idx_o   = res_valid_o ? nb_q : '0;
  assign res_data_o  = res_valid_o ? rd : '0;

endmodule
